slavefifo2b_stream_in_writer: RTL and testbench

- Stream-IN master for the FX3 Slave FIFO 2-bit interface: FPGA → FX3 direction, the write-side counterpart of the stream-OUT reader.
- Sources an incrementing 32-bit test pattern and drives the write strobe under FX3 thread flag control.
- Sits beside the stream-OUT reader in the slaveFIFO2b top. The top muxes its outputs onto the shared SLWR_/PKTEND_/DQ pins when stream-IN mode is selected.
- Flag inputs arrive already registered (one-cycle delayed copies of the FX3 pins).

---
 rtl/slavefifo2b_pkg.sv | 17 +
 rtl/slavefifo2b_pattern_gen.sv | 40 ++++
 rtl/slavefifo2b_stream_in_writer.sv | 104 ++++++++++
 tb/tb_slavefifo2b_stream_in_writer.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/slavefifo2b_pkg.sv
// Shared definitions for the FX3 Slave FIFO 2-bit stream blocks: state encoding,
// data width and default inter-burst delay.
package slavefifo2b_pkg;

    localparam int FX3_DATA_W          = 32;
    localparam int WR_DELAY_CYCLES_DEF = 3;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FLAGA_RCVD = 3'd1,
        ST_WAIT_FLAGB = 3'd2,
        ST_WRITE      = 3'd3,
        ST_WR_DELAY   = 3'd4,
        ST_PKTEND     = 3'd5
    } state_e;

endpackage

// File: rtl/slavefifo2b_pattern_gen.sv
// Incrementing 32-bit test pattern plus running word counter; both advance
// once per written word and wrap modulo 2^32.
module slavefifo2b_pattern_gen
    import slavefifo2b_pkg::*;
#(
    parameter logic [FX3_DATA_W-1:0] DATA_INIT = '0
) (
    input  logic                  clk_100,
    input  logic                  reset_,
    input  logic                  enable,
    output logic [FX3_DATA_W-1:0] data,
    output logic [31:0]           count
);

    logic [FX3_DATA_W-1:0] data_q, data_d;
    logic [31:0]           count_q, count_d;

    always_comb begin
        data_d  = data_q;
        count_d = count_q;
        if (enable) begin
            data_d  = data_q + 1'b1;
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_100 or negedge reset_) begin
        if (!reset_) begin
            data_q  <= DATA_INIT;
            count_q <= '0;
        end else begin
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    assign data  = data_q;
    assign count = count_q;

endmodule

// File: rtl/slavefifo2b_stream_in_writer.sv
// Stream-IN master (FPGA -> FX3): writes an incrementing pattern under FX3 flag control.
// Optional short-packet commit on mode drop is enabled by STREAM_IN_PKTEND_EN.
//
//   state       | meaning
//   ------------+---------------------------------------------------------
//   idle        | waiting for stream-IN mode and thread-ready (flaga)
//   flaga_rcvd  | thread ready seen, one settle cycle
//   wait_flagb  | waiting for space above watermark (flagb)
//   write       | strobing one word per cycle
//   wr_delay    | post-burst settle, down-counter to zero
//   pktend      | one-cycle packet-end strobe (optional feature only)
module slavefifo2b_stream_in_writer
    import slavefifo2b_pkg::*;
#(
    parameter logic [FX3_DATA_W-1:0] DATA_INIT       = 32'd0,
    parameter int                    WR_DELAY_CYCLES = WR_DELAY_CYCLES_DEF
) (
    input  logic                  clk_100,
    input  logic                  reset_,
    input  logic                  stream_in_mode_selected,
    input  logic                  flaga_d,
    input  logic                  flagb_d,
    output logic                  slwr_streamIN_,
    output logic                  pktend_streamIN_,
    output logic [FX3_DATA_W-1:0] data_out_stream_in,
    output logic [31:0]           words_written
);

    localparam logic [3:0] DLY_LOAD = 4'(WR_DELAY_CYCLES - 1);

    state_e     state_q, state_d;
    logic [3:0] dly_q, dly_d;

    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        case (state_q)
            ST_IDLE: begin
                if (stream_in_mode_selected && flaga_d) state_d = ST_FLAGA_RCVD;
            end
            ST_FLAGA_RCVD: state_d = ST_WAIT_FLAGB;
            ST_WAIT_FLAGB: begin
                if (!stream_in_mode_selected) state_d = ST_IDLE;
                else if (flagb_d)             state_d = ST_WRITE;
            end
            ST_WRITE: begin
`ifdef STREAM_IN_PKTEND_EN
                // Being in write means this cycle strobes a word, so a burst
                // ending on mode drop always has data to commit.
                if (!stream_in_mode_selected) begin
                    state_d = ST_PKTEND;
                end else if (!flagb_d) begin
                    state_d = ST_WR_DELAY;
                    dly_d   = DLY_LOAD;
                end
`else
                if (!stream_in_mode_selected || !flagb_d) begin
                    state_d = ST_WR_DELAY;
                    dly_d   = DLY_LOAD;
                end
`endif
            end
`ifdef STREAM_IN_PKTEND_EN
            ST_PKTEND: begin
                state_d = ST_WR_DELAY;
                dly_d   = DLY_LOAD;
            end
`endif
            ST_WR_DELAY: begin
                if (dly_q == 4'd0) state_d = ST_IDLE;
                else               dly_d   = dly_q - 4'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_100 or negedge reset_) begin
        if (!reset_) begin
            state_q <= ST_IDLE;
            dly_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
        end
    end

    assign slwr_streamIN_ = (state_q != ST_WRITE);
`ifdef STREAM_IN_PKTEND_EN
    assign pktend_streamIN_ = (state_q != ST_PKTEND);
`else
    assign pktend_streamIN_ = 1'b1;
`endif

    slavefifo2b_pattern_gen #(
        .DATA_INIT (DATA_INIT)
    ) u_pattern (
        .clk_100 (clk_100),
        .reset_  (reset_),
        .enable  (!slwr_streamIN_),
        .data    (data_out_stream_in),
        .count   (words_written)
    );

endmodule

// File: tb/tb_slavefifo2b_stream_in_writer.sv
// Bench for slavefifo2b_stream_in_writer: two instances (DATA_INIT 0 and FFFF_FFFE)
// share stimulus; expected strobe windows are recorded per burst and checked every cycle.
module tb_slavefifo2b_stream_in_writer;

`ifdef STREAM_IN_PKTEND_EN
    localparam bit PKT_EN = 1'b1;
`else
    localparam bit PKT_EN = 1'b0;
`endif
    localparam logic [31:0] INIT1 = 32'hFFFF_FFFE;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic mode = 1'b0, fa = 1'b0, fb = 1'b0;
    logic slwr0, pk0, slwr1, pk1;
    logic [31:0] d0, w0, d1, w1;

    always #5 clk = ~clk;

    slavefifo2b_stream_in_writer #(.DATA_INIT(32'd0), .WR_DELAY_CYCLES(3)) dut0 (
        .clk_100(clk), .reset_(rst_n), .stream_in_mode_selected(mode),
        .flaga_d(fa), .flagb_d(fb), .slwr_streamIN_(slwr0), .pktend_streamIN_(pk0),
        .data_out_stream_in(d0), .words_written(w0));

    slavefifo2b_stream_in_writer #(.DATA_INIT(INIT1), .WR_DELAY_CYCLES(3)) dut1 (
        .clk_100(clk), .reset_(rst_n), .stream_in_mode_selected(mode),
        .flaga_d(fa), .flagb_d(fb), .slwr_streamIN_(slwr1), .pktend_streamIN_(pk1),
        .data_out_stream_in(d1), .words_written(w1));

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    logic [31:0] model_words = 32'd0;
    int win_s[$];
    int win_e[$];
    int pkt_c[$];

    function automatic bit exp_strobe(int c);
        foreach (win_s[i]) if (c >= win_s[i] && c <= win_e[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit exp_pkt(int c);
        foreach (pkt_c[i]) if (c == pkt_c[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Words written so far = strobe cycles completed since the last reset.
    always @(posedge clk) begin
        if (rst_n && exp_strobe(cyc)) model_words = model_words + 32'd1;
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        bit s;
        bit p;
        if (rst_n) begin
            s = exp_strobe(cyc);
            p = exp_pkt(cyc);
            check("slwr0",   32'(slwr0), 32'(!s));
            check("slwr1",   32'(slwr1), 32'(!s));
            check("pktend0", 32'(pk0),   32'(!p));
            check("pktend1", 32'(pk1),   32'(!p));
            check("data0",   d0, model_words);
            check("data1",   d1, INIT1 + model_words);
            check("words0",  w0, model_words);
            check("words1",  w1, model_words);
        end
    end

    initial begin
        int c0;
        int e;
        int i0;
        int r;
        #1 rst_n = 1'b0;
        #1;
        check("rst_slwr",   32'(slwr0), 32'd1);
        check("rst_pktend", 32'(pk0),   32'd1);
        check("rst_data0",  d0, 32'd0);
        check("rst_data1",  d1, 32'hFFFF_FFFE);
        check("rst_words",  w0, 32'd0);
        tick(2);

        // Burst 1: flags ready at reset release, flagb drops after 10 strobes.
        rst_n = 1'b1; mode = 1'b1; fa = 1'b1; fb = 1'b1;
        c0 = cyc;
        win_s.push_back(c0 + 3); win_e.push_back(1 << 30);
        tick(2);
        check("pre_strobe_c2", 32'(slwr0), 32'd1);
        tick(1);
        check("first_strobe", 32'(slwr0), 32'd0);
        check("first_data0",  d0, 32'd0);
        check("first_data1",  d1, 32'hFFFF_FFFE);
        tick(9);
        fb = 1'b0; win_e[0] = cyc;
        tick(1);
        fb = 1'b1;
        tick(3);
        check("burst1_words", w0, 32'd10);
        check("burst1_next",  d0, 32'd10);
        check("burst1_idle",  32'(slwr0), 32'd1);

        // Burst 2 re-arbitrates from idle, then mode drops after 5 strobes.
        win_s.push_back(cyc + 3); win_e.push_back(1 << 30);
        tick(3);
        check("burst2_start", 32'(slwr0), 32'd0);
        check("burst2_data",  d0, 32'd10);
        tick(4);
        mode = 1'b0; fa = 1'b0; e = cyc; win_e[1] = e;
        if (PKT_EN) pkt_c.push_back(e + 1);
        tick(1);
        check("drop_slwr",   32'(slwr0), 32'd1);
        check("drop_pktend", 32'(pk0), PKT_EN ? 32'd0 : 32'd1);
        check("drop_words",  w0, 32'd15);
        tick(1);

        // flaga low with mode high: no arbitration at all.
        mode = 1'b1;
        tick(100);
        check("noflaga_words", w0, 32'd15);
        check("noflaga_slwr",  32'(slwr0), 32'd1);
        check("noflaga_data1", d1, 32'h0000_000D);

        // Burst 3, interrupted by an asynchronous reset after 2 strobes.
        fa = 1'b1; i0 = cyc;
        win_s.push_back(i0 + 3); win_e.push_back(1 << 30);
        tick(4);
        #2;
        rst_n = 1'b0; win_e[2] = cyc - 1; model_words = 32'd0;
        #1;
        check("async_slwr0", 32'(slwr0), 32'd1);
        check("async_slwr1", 32'(slwr1), 32'd1);
        check("async_data0", d0, 32'd0);
        check("async_data1", d1, 32'hFFFF_FFFE);
        check("async_words", w0, 32'd0);

        // Burst 4 after reset: DATA_INIT=FFFF_FFFE wraps through zero.
        tick(1);
        rst_n = 1'b1; mode = 1'b1; fa = 1'b1; fb = 1'b1;
        r = cyc;
        win_s.push_back(r + 3); win_e.push_back(1 << 30);
        tick(3);
        check("wrap_w0", d1, 32'hFFFF_FFFE);
        tick(2);
        check("wrap_w2", d1, 32'd0);
        tick(1);
        check("wrap_w3", d1, 32'd1);
        fb = 1'b0; win_e[3] = cyc; mode = 1'b0;
        tick(6);
        check("final_words", w1, 32'd4);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
